// File: rtl/force_seq_ctrl.sv
// Upstream control for the d_ff register stage: registers the data stream and
// runs the request-driven preset window (FORCE -> HOLD -> IDLE with done pulse).
module force_seq_ctrl #(
  parameter int WIDTH   = 1,
  parameter int CNT_W   = 8,
  parameter int HOLDOFF = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_in,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_val,
  input  logic [CNT_W-1:0] req_len,
  input  logic             abort,
  output logic [WIDTH-1:0] d_out,
  output logic             preset,
  output logic [WIDTH-1:0] force_val,
  output logic             busy,
  output logic             done
);

  // Hold counter only needs to reach HOLDOFF, so size it from that value.
  localparam int HW = $clog2(HOLDOFF + 1);

  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [HW-1:0]    HOLD_ONE  = HW'(1);
  localparam logic [HW-1:0]    HOLD_LOAD = HW'(HOLDOFF);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FORCE = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [HW-1:0]    hold_cnt, hold_cnt_nxt;
  logic             preset_nxt;
  logic [WIDTH-1:0] force_val_nxt;
  logic             done_nxt;
  logic             accept;

  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign accept    = req_valid & req_ready;

  // Data path: plain 1-cycle register, independent of the override FSM.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values, regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      d_out <= '0;
    end else begin
      d_out <= d_in;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      hold_cnt  <= '0;
      preset    <= 1'b0;
      force_val <= '0;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      hold_cnt  <= hold_cnt_nxt;
      preset    <= preset_nxt;
      force_val <= force_val_nxt;
      done      <= done_nxt;
    end
  end

  // NOTE: every always_comb output gets a default first so no path can leave
  // a signal unassigned and infer a latch.
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    hold_cnt_nxt  = hold_cnt;
    preset_nxt    = preset;
    force_val_nxt = force_val;
    done_nxt      = 1'b0;

    unique case (state)
      IDLE: begin
        if (accept) begin
          if (req_len != '0) begin
            state_nxt     = FORCE;
            cnt_nxt       = req_len;
            preset_nxt    = 1'b1;
            force_val_nxt = req_val;
          end else begin
            // Zero-length request completes without ever raising preset.
            done_nxt = 1'b1;
          end
        end
      end

      FORCE: begin
        // cnt is never 0 here, so the decrement cannot wrap.
        if (abort || (cnt == CNT_ONE)) begin
          state_nxt    = HOLD;
          cnt_nxt      = '0;
          preset_nxt   = 1'b0;
          hold_cnt_nxt = HOLD_LOAD;
        end else begin
          cnt_nxt = cnt - CNT_ONE;
        end
      end

      HOLD: begin
        if (hold_cnt == HOLD_ONE) begin
          state_nxt    = IDLE;
          hold_cnt_nxt = '0;
          done_nxt     = 1'b1;
        end else begin
          hold_cnt_nxt = hold_cnt - HOLD_ONE;
        end
      end

      default: begin
        state_nxt  = IDLE;
        preset_nxt = 1'b0;
      end
    endcase
  end

endmodule
